// File: rtl/ex_pkg.sv
// Shared types and opcode constants for the execute stage and its iterative
// multiply/divide unit.
package ex_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00,
    ALUOP_SUB = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } aluop_e;

  // 2'b11 intentionally selects the register value, same as 2'b00
  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_WB      = 2'b01,
    FWD_MEM     = 2'b10,
    FWD_REG_ALT = 2'b11
  } fwd_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_e;

  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/ex_stage_md_if.sv
// ID/EX operand bundle in, EX/MEM results and stall out.
interface ex_stage_md_if #(
  parameter int XLEN = 32
);
  logic            valid_ex;
  logic [XLEN-1:0] imm_ex;
  logic [XLEN-1:0] reg_data1_ex;
  logic [XLEN-1:0] reg_data2_ex;
  logic [XLEN-1:0] pc_ex;
  logic [2:0]      funct3_ex;
  logic [6:0]      funct7_ex;
  logic [1:0]      aluop_ex;
  logic            alusrc_ex;
  logic [1:0]      forward_a;
  logic [1:0]      forward_b;
  logic [XLEN-1:0] alu_data_wb;
  logic [XLEN-1:0] alu_out_mem;
  logic            mem_stall;
  logic            stall_ex;
  logic            md_busy;
  logic            zero_ex;
  logic [XLEN-1:0] alu_out_ex;
  logic [XLEN-1:0] pc_branch_ex;
  logic [XLEN-1:0] reg_data2_final;

  modport master (
    output valid_ex, imm_ex, reg_data1_ex, reg_data2_ex, pc_ex, funct3_ex, funct7_ex,
           aluop_ex, alusrc_ex, forward_a, forward_b, alu_data_wb, alu_out_mem, mem_stall,
    input  stall_ex, md_busy, zero_ex, alu_out_ex, pc_branch_ex, reg_data2_final
  );

  modport slave (
    input  valid_ex, imm_ex, reg_data1_ex, reg_data2_ex, pc_ex, funct3_ex, funct7_ex,
           aluop_ex, alusrc_ex, forward_a, forward_b, alu_data_wb, alu_out_mem, mem_stall,
    output stall_ex, md_busy, zero_ex, alu_out_ex, pc_branch_ex, reg_data2_final
  );
endinterface

// File: rtl/md_iter.sv
// Iterative RV32M unit: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, with sign fix-up applied when the result is presented.
module md_iter
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            mem_stall,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc;       // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [2:0]        op_q;
  logic              sign_a, sign_b;

  logic              is_div, a_signed, b_signed, sa, sb, div_zero, overflow;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     add_sum, sub_diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    is_div   = funct3[2];
    a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    sa       = a_signed & op_a[XLEN-1];
    sb       = b_signed & op_b[XLEN-1];
    abs_a    = sa ? -op_a : op_a;
    abs_b    = sb ? -op_b : op_b;
    div_zero = is_div && (op_b == '0);
    overflow = is_div && !funct3[0] && (op_a == MIN_VAL) && (op_b == '1);
  end

  // One iteration of each algorithm; BUSY picks the one matching op_q.
  always_comb begin
    add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
    mul_next = {add_sum, acc[XLEN-1:1]};
    sub_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    div_next = sub_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                              : {sub_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    // NOTE: operand and accumulator registers are cleared along with the FSM,
    // so a reset mid-operation leaves nothing of the partial result behind.
    if (!reset_n) begin
      state  <= MD_IDLE;
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      case (state)
        MD_IDLE: if (start) begin
          op_q <= funct3;
          if (div_zero) begin
            acc    <= {op_a, {XLEN{1'b1}}};
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            state  <= MD_DONE;
          end else if (overflow) begin
            acc    <= {{XLEN{1'b0}}, MIN_VAL};
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            state  <= MD_DONE;
          end else begin
            acc    <= {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
            opnd   <= is_div ? abs_b : abs_a;
            sign_a <= sa;
            sign_b <= sb;
            count  <= CW'(XLEN - 1);
            state  <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          acc   <= op_q[2] ? div_next : mul_next;
          count <= count - CW'(1);
          if (count == '0) state <= MD_DONE;
        end
        MD_DONE: if (!mem_stall) state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

  always_comb begin
    prod   = (sign_a ^ sign_b) ? -acc : acc;
    quo    = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem    = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    result = '0;
    if (state == MD_DONE) begin
      case (op_q)
        F3_MUL:                      result = prod[XLEN-1:0];
        F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*XLEN-1:XLEN];
        F3_DIV, F3_DIVU:             result = quo;
        default:                     result = rem;
      endcase
    end
  end

  assign stall = ((state == MD_IDLE) && start) || (state == MD_BUSY);
  assign busy  = (state != MD_IDLE);
  assign done  = (state == MD_DONE);

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: forwarding muxes, ALU decode, single-cycle ALU, branch adder,
// and the iterative M-extension unit that freezes upstream while it runs.
module ex_stage_md
  import ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit MD_EN = 1'b1
) (
  input logic        clk,
  input logic        reset_n,
  ex_stage_md_if.slave bus
);

  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] op_a, rs2, op_b, alu_res, md_result, alu_out;
  logic [SW-1:0]   shamt;
  alu_ctrl_e       ctrl;
  logic            is_m_op, md_start, md_stall, md_busy, md_done;

  always_comb begin
    case (bus.forward_a)
      FWD_WB:  op_a = bus.alu_data_wb;
      FWD_MEM: op_a = bus.alu_out_mem;
      default: op_a = bus.reg_data1_ex;
    endcase
    case (bus.forward_b)
      FWD_WB:  rs2 = bus.alu_data_wb;
      FWD_MEM: rs2 = bus.alu_out_mem;
      default: rs2 = bus.reg_data2_ex;
    endcase
    op_b = bus.alusrc_ex ? bus.imm_ex : rs2;
  end

  always_comb begin
    // NOTE: default first, so every path through the decode assigns ctrl and no latch is inferred.
    ctrl = ALU_ADD;
    case (bus.aluop_ex)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      default: begin
        // funct7[5] selects SUB only for R-type; for immediates it only marks SRAI
        case (bus.funct3_ex)
          3'b000:  ctrl = (bus.aluop_ex == ALUOP_R && bus.funct7_ex[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  ctrl = ALU_SLL;
          3'b010:  ctrl = ALU_SLT;
          3'b011:  ctrl = ALU_SLTU;
          3'b100:  ctrl = ALU_XOR;
          3'b101:  ctrl = bus.funct7_ex[5] ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl = ALU_OR;
          default: ctrl = ALU_AND;
        endcase
      end
    endcase
  end

  always_comb begin
    shamt = op_b[SW-1:0];
    case (ctrl)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = '0;
    endcase
  end

  assign is_m_op  = (bus.aluop_ex == ALUOP_R) && (bus.funct7_ex == FUNCT7_M);
  assign md_start = MD_EN && bus.valid_ex && is_m_op;

  md_iter #(.XLEN(XLEN)) u_md_iter (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (md_start),
    .funct3    (bus.funct3_ex),
    .op_a      (op_a),
    .op_b      (rs2),
    .mem_stall (bus.mem_stall),
    .stall     (md_stall),
    .busy      (md_busy),
    .done      (md_done),
    .result    (md_result)
  );

  // Without the M unit, M opcodes retire as 0 rather than an accidental ALU result.
  assign alu_out = md_done ? md_result : ((is_m_op && !MD_EN) ? '0 : alu_res);

  assign bus.alu_out_ex      = alu_out;
  assign bus.zero_ex         = (alu_out == '0);
  assign bus.pc_branch_ex    = bus.pc_ex + bus.imm_ex;
  assign bus.reg_data2_final = rs2;
  assign bus.stall_ex        = md_stall;
  assign bus.md_busy         = md_busy;

endmodule
